// File: rtl/color_scan_scheduler.sv
// Purpose: time-shares one edge-counting path between the object and station colour sensors, scanning red/green/blue per request.
// Latency: request to valid pulse is 3*(SETTLE_US+GATE_US) tick_us pulses plus at most 3 clk.
// Backpressure: none; the colour is held between scans and valid is a one-clk pulse the core must take when it appears.
module color_scan_scheduler #(
   parameter int GATE_US   = 2000,
   parameter int SETTLE_US = 200,
   parameter int CNT_W     = 12,
   parameter int MIN_CNT   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_us,
   input  logic       en_object,
   input  logic       en_station,
   input  logic       object_wave,
   input  logic       station_wave,
   output logic [1:0] object_select,
   output logic [1:0] station_select,
   output logic       object_led,
   output logic       station_led,
   output logic [1:0] object_color,
   output logic [1:0] station_color,
   output logic       object_valid,
   output logic       station_valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_GATE     = 2'd2,
      ST_CLASSIFY = 2'd3
   } state_t;

   // Sensor filter select coding
   localparam logic [1:0] SEL_RED   = 2'b00;
   localparam logic [1:0] SEL_GREEN = 2'b11;
   localparam logic [1:0] SEL_BLUE  = 2'b01;
   localparam logic [1:0] SEL_CLEAR = 2'b10;

   // Reported colour coding
   localparam logic [1:0] COL_NONE  = 2'd0;
   localparam logic [1:0] COL_RED   = 2'd1;
   localparam logic [1:0] COL_GREEN = 2'd2;
   localparam logic [1:0] COL_BLUE  = 2'd3;

   localparam int                TICK_MAX    = (GATE_US > SETTLE_US) ? GATE_US : SETTLE_US;
   localparam int                TICK_W      = $clog2(TICK_MAX + 1);
   localparam logic [TICK_W-1:0] SETTLE_LAST = TICK_W'(SETTLE_US - 1);
   localparam logic [TICK_W-1:0] GATE_LAST   = TICK_W'(GATE_US - 1);
   localparam logic [CNT_W-1:0]  CNT_SAT     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_MIN     = CNT_W'(MIN_CNT);

   state_t             state;
   state_t             state_nxt;
   logic               served_station;   // 0: object sensor, 1: station sensor
   logic               prefer_station;   // round-robin pointer used when both request
   logic [1:0]         idx;              // 0 red, 1 green, 2 blue
   logic [TICK_W-1:0]  tick_cnt;
   logic [CNT_W-1:0]   edge_cnt;
   logic [CNT_W-1:0]   edge_nxt;
   logic [CNT_W-1:0]   red_cnt;
   logic [CNT_W-1:0]   green_cnt;
   logic [CNT_W-1:0]   blue_cnt;

   logic [1:0]         obj_sync;
   logic [1:0]         sta_sync;
   logic               obj_prev;
   logic               sta_prev;
   logic               obj_rise;
   logic               sta_rise;
   logic               served_rise;
   logic               served_en;
   logic               any_req;
   logic               pick_station;
   logic               settle_done;
   logic               gate_done;
   logic               last_filter;
   logic [1:0]         filt_sel;
   logic [1:0]         cls_color;
   logic [CNT_W-1:0]   max_cnt;

   // Two-flop synchronisers plus a history flop for rising-edge detection on both waves
   always_ff @(posedge clk) begin
      if (rst) begin
         obj_sync <= 2'b00;
         sta_sync <= 2'b00;
         obj_prev <= 1'b0;
         sta_prev <= 1'b0;
      end else begin
         obj_sync <= {obj_sync[0], object_wave};
         sta_sync <= {sta_sync[0], station_wave};
         obj_prev <= obj_sync[1];
         sta_prev <= sta_sync[1];
      end
   end

   assign obj_rise    = obj_sync[1] & ~obj_prev;
   assign sta_rise    = sta_sync[1] & ~sta_prev;
   assign served_rise = served_station ? sta_rise : obj_rise;
   assign served_en   = served_station ? en_station : en_object;
   assign any_req     = en_object | en_station;
   // Station wins only if it is the sole requester or it is its round-robin turn
   assign pick_station = en_station & (~en_object | prefer_station);
   assign settle_done  = tick_us & (tick_cnt == SETTLE_LAST);
   assign gate_done    = tick_us & (tick_cnt == GATE_LAST);
   assign last_filter  = (idx == 2'd2);
   // An edge in the final gate clk is still counted; the counter sticks at full scale
   assign edge_nxt     = (served_rise && (edge_cnt != CNT_SAT)) ? edge_cnt + CNT_W'(1) : edge_cnt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: scan sequencing with abort when the served request drops
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (any_req) state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!served_en)       state_nxt = ST_IDLE;
            else if (settle_done) state_nxt = ST_GATE;
         end
         ST_GATE: begin
            if (!served_en)     state_nxt = ST_IDLE;
            else if (gate_done) state_nxt = last_filter ? ST_CLASSIFY : ST_SETTLE;
         end
         ST_CLASSIFY: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Scan datapath: sensor choice, filter index, tick/edge counters and per-channel results
   always_ff @(posedge clk) begin
      if (rst) begin
         served_station <= 1'b0;
         idx            <= 2'd0;
         tick_cnt       <= '0;
         edge_cnt       <= '0;
         red_cnt        <= '0;
         green_cnt      <= '0;
         blue_cnt       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  served_station <= pick_station;
                  idx            <= 2'd0;
                  tick_cnt       <= '0;
                  edge_cnt       <= '0;
                  red_cnt        <= '0;
                  green_cnt      <= '0;
                  blue_cnt       <= '0;
               end
            end
            ST_SETTLE: begin
               if (settle_done) begin
                  tick_cnt <= '0;
                  edge_cnt <= '0;
               end else if (tick_us) begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end
            end
            ST_GATE: begin
               edge_cnt <= edge_nxt;
               if (gate_done) begin
                  tick_cnt <= '0;
                  case (idx)
                     2'd0:    red_cnt   <= edge_nxt;
                     2'd1:    green_cnt <= edge_nxt;
                     default: blue_cnt  <= edge_nxt;
                  endcase
                  if (!last_filter) idx <= idx + 2'd1;
               end else if (tick_us) begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Classifier: largest channel wins, ties resolved red over green over blue, dim readings report none
   always_comb begin
      cls_color = COL_RED;
      max_cnt   = red_cnt;
      if ((red_cnt >= green_cnt) && (red_cnt >= blue_cnt)) begin
         cls_color = COL_RED;
         max_cnt   = red_cnt;
      end else if (green_cnt >= blue_cnt) begin
         cls_color = COL_GREEN;
         max_cnt   = green_cnt;
      end else begin
         cls_color = COL_BLUE;
         max_cnt   = blue_cnt;
      end
      if (max_cnt < CNT_MIN) cls_color = COL_NONE;
   end

   // Result registers: colour held between scans, valid pulses once, pointer advances only on completed scans
   always_ff @(posedge clk) begin
      if (rst) begin
         object_color   <= COL_NONE;
         station_color  <= COL_NONE;
         object_valid   <= 1'b0;
         station_valid  <= 1'b0;
         prefer_station <= 1'b0;
      end else begin
         object_valid  <= 1'b0;
         station_valid <= 1'b0;
         if (state == ST_CLASSIFY) begin
            if (served_station) begin
               station_color <= cls_color;
               station_valid <= 1'b1;
            end else begin
               object_color <= cls_color;
               object_valid <= 1'b1;
            end
            prefer_station <= ~served_station;
         end
      end
   end

   // Filter code for the current scan step
   always_comb begin
      case (idx)
         2'd0:    filt_sel = SEL_RED;
         2'd1:    filt_sel = SEL_GREEN;
         default: filt_sel = SEL_BLUE;
      endcase
   end

   // Sensor pin outputs: only the served sensor is lit and filtered, the other sits on clear with LED off
   always_comb begin
      object_select  = SEL_CLEAR;
      station_select = SEL_CLEAR;
      object_led     = 1'b0;
      station_led    = 1'b0;
      busy           = (state != ST_IDLE);
      if (state != ST_IDLE) begin
         if (served_station) begin
            station_select = filt_sel;
            station_led    = 1'b1;
         end else begin
            object_select = filt_sel;
            object_led    = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_color_scan_scheduler.sv
module tb_color_scan_scheduler;

   logic       clk;
   logic       rst;
   logic       tick_us;
   logic       en_object;
   logic       en_station;
   logic       object_wave;
   logic       station_wave;
   logic [1:0] object_select;
   logic [1:0] station_select;
   logic       object_led;
   logic       station_led;
   logic [1:0] object_color;
   logic [1:0] station_color;
   logic       object_valid;
   logic       station_valid;
   logic       busy;

   color_scan_scheduler #(
      .GATE_US   (100),
      .SETTLE_US (10),
      .CNT_W     (6),
      .MIN_CNT   (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .tick_us        (tick_us),
      .en_object      (en_object),
      .en_station     (en_station),
      .object_wave    (object_wave),
      .station_wave   (station_wave),
      .object_select  (object_select),
      .station_select (station_select),
      .object_led     (object_led),
      .station_led    (station_led),
      .object_color   (object_color),
      .station_color  (station_color),
      .object_valid   (object_valid),
      .station_valid  (station_valid),
      .busy           (busy)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Sensor model: per sensor and filter, a burst of N rising edges or continuous toggling
   int   cfg_n    [2][3];
   bit   cfg_cont [2][3];
   logic wv       [2];
   logic [1:0] m_last [2];
   int   m_delay  [2];
   int   m_left   [2];
   bit   m_cont   [2];
   logic [1:0] cur_sel;
   logic cur_led;
   int   cur_f;

   // Monitor counters
   int n_ov = 0;
   int n_sv = 0;
   int inv_bad = 0;
   int sta_led_cyc = 0;

   int who;
   int lat;
   int n;
   int ov_snap;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // tick_us every 10 clk
   initial begin
      tick_us = 1'b0;
      forever begin
         repeat (9) @(negedge clk);
         tick_us = 1'b1;
         @(negedge clk);
         tick_us = 1'b0;
      end
   end

   function automatic int filt_index(input logic [1:0] sel);
      case (sel)
         2'b11:   return 1;
         2'b01:   return 2;
         default: return 0;
      endcase
   endfunction

   // Edges start 150 clk after a filter change, i.e. safely inside the gate window
   initial begin
      for (int s = 0; s < 2; s++) begin
         wv[s] = 1'b0; m_last[s] = 2'b10; m_delay[s] = 0; m_left[s] = 0; m_cont[s] = 1'b0;
      end
      object_wave  = 1'b0;
      station_wave = 1'b0;
      forever begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            cur_sel = (s == 0) ? object_select : station_select;
            cur_led = (s == 0) ? object_led : station_led;
            if (!cur_led) begin
               wv[s] = 1'b0; m_last[s] = 2'b10; m_delay[s] = 0; m_left[s] = 0; m_cont[s] = 1'b0;
            end else begin
               if (cur_sel != m_last[s]) begin
                  m_last[s]  = cur_sel;
                  cur_f      = filt_index(cur_sel);
                  m_delay[s] = 150;
                  m_left[s]  = 2 * cfg_n[s][cur_f];
                  m_cont[s]  = cfg_cont[s][cur_f];
               end
               if (m_delay[s] > 0) begin
                  m_delay[s] = m_delay[s] - 1;
               end else if (m_cont[s]) begin
                  wv[s] = ~wv[s];
               end else if (m_left[s] > 0) begin
                  wv[s] = ~wv[s];
                  m_left[s] = m_left[s] - 1;
               end
            end
         end
         object_wave  = wv[0];
         station_wave = wv[1];
      end
   end

   // Monitor: valid pulses, idle-sensor pin invariant, station LED activity
   initial begin
      forever begin
         @(negedge clk);
         if (object_valid)  n_ov++;
         if (station_valid) n_sv++;
         if ((!object_led && object_select != 2'b10) || (!station_led && station_select != 2'b10) ||
             (object_led && station_led))
            inv_bad++;
         if (station_led) sta_led_cyc++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input int s, input int r, input int g, input int b);
      cfg_n[s][0] = r; cfg_n[s][1] = g; cfg_n[s][2] = b;
      cfg_cont[s][0] = 1'b0; cfg_cont[s][1] = 1'b0; cfg_cont[s][2] = 1'b0;
   endtask

   // Waits up to 6000 clk for a valid pulse; who = 1 object, 2 station, 0 timeout
   task automatic wait_valid(output int w, output int l);
      w = 0;
      l = 0;
      while (w == 0 && l < 6000) begin
         @(negedge clk);
         l++;
         if (object_valid)       w = 1;
         else if (station_valid) w = 2;
      end
   endtask

   initial begin
      rst = 1'b1; en_object = 1'b0; en_station = 1'b0;
      set_cfg(0, 0, 0, 0);
      set_cfg(1, 0, 0, 0);
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_obj_sel", 32'(object_select), 32'h2);
      check("rst_sta_sel", 32'(station_select), 32'h2);
      check("rst_leds", 32'({object_led, station_led}), 32'h0);
      check("rst_colors", 32'({object_color, station_color}), 32'h0);
      check("rst_valids_busy", 32'({object_valid, station_valid, busy}), 32'h0);
      rst = 1'b0;

      // 1) Object scan, red dominant
      set_cfg(0, 50, 20, 10);
      en_object = 1'b1;
      wait_valid(who, lat);
      en_object = 1'b0;
      check("t1_who", 32'(who), 32'd1);
      check("t1_color", 32'(object_color), 32'd1);
      check("t1_latency_in_range", 32'(lat >= 3290 && lat <= 3305), 32'd1);
      @(negedge clk);
      check("t1_valid_one_clk", 32'(object_valid), 32'd0);
      check("t1_idle_after", 32'({busy, object_led, object_select}), 32'h2);
      check("t1_station_untouched", 32'({n_sv, sta_led_cyc, station_color}), 32'h0);

      // 2) Station scans: green by a narrow margin, then too dim
      set_cfg(1, 12, 40, 39);
      en_station = 1'b1;
      wait_valid(who, lat);
      en_station = 1'b0;
      check("t2a_who", 32'(who), 32'd2);
      check("t2a_color", 32'(station_color), 32'd2);
      set_cfg(1, 3, 5, 7);
      @(negedge clk);
      en_station = 1'b1;
      wait_valid(who, lat);
      en_station = 1'b0;
      check("t2b_who", 32'(who), 32'd2);
      check("t2b_color_dark", 32'(station_color), 32'd0);
      check("t2_object_color_held", 32'(object_color), 32'd1);

      // 3) Continuous dual requests alternate O,S,O,S
      set_cfg(0, 5, 30, 60);
      set_cfg(1, 40, 10, 12);
      @(negedge clk);
      en_object = 1'b1; en_station = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_valid(who, lat);
         if (k == 3) begin
            en_object = 1'b0; en_station = 1'b0;
         end
         if (k % 2 == 0) begin
            check("t3_who_object", 32'(who), 32'd1);
            check("t3_object_color", 32'(object_color), 32'd3);
         end else begin
            check("t3_who_station", 32'(who), 32'd2);
            check("t3_station_color", 32'(station_color), 32'd1);
         end
      end
      check("t3_idle_pins_invariant", 32'(inv_bad), 32'd0);

      // 4) Abort during the green gate
      set_cfg(0, 50, 20, 10);
      @(negedge clk);
      en_object = 1'b1;
      n = 0;
      while (object_select != 2'b11 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("t4_reached_green", 32'(n < 5000), 32'd1);
      repeat (150) @(negedge clk);
      check("t4_busy_in_gate", 32'({busy, object_led}), 32'h3);
      ov_snap = n_ov;
      en_object = 1'b0;
      @(negedge clk);
      check("t4_abort_idle", 32'({busy, object_led, object_select}), 32'h2);
      repeat (50) @(negedge clk);
      check("t4_no_valid", 32'(n_ov), 32'(ov_snap));
      check("t4_color_held", 32'(object_color), 32'd3);

      // 5) Saturation: red and green toggle every clk, blue 60 edges; red must win on tie at 63
      set_cfg(0, 0, 0, 60);
      cfg_cont[0][0] = 1'b1;
      cfg_cont[0][1] = 1'b1;
      en_object = 1'b1;
      wait_valid(who, lat);
      en_object = 1'b0;
      check("t5_who", 32'(who), 32'd1);
      check("t5_sat_red_priority", 32'(object_color), 32'd1);

      // 6) Reset mid-gate then restart from red
      set_cfg(0, 50, 20, 10);
      @(negedge clk);
      en_object = 1'b1;
      n = 0;
      while (!object_led && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t6_started", 32'(object_led), 32'd1);
      repeat (200) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_sel", 32'({object_select, station_select}), 32'hA);
      check("t6_rst_leds_busy", 32'({object_led, station_led, busy}), 32'h0);
      check("t6_rst_colors_valids", 32'({object_color, station_color, object_valid, station_valid}), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("t6_restart_red", 32'({object_led, object_select}), 32'h4);
      wait_valid(who, lat);
      en_object = 1'b0;
      check("t6_who", 32'(who), 32'd1);
      check("t6_color", 32'(object_color), 32'd1);
      check("final_idle_pins_invariant", 32'(inv_bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
